fpu_seq_ctrl: RTL and testbench
===============================

// Module: fpu_seq_ctrl
// PURPOSE
//  Sequencer that lets the single-cycle core issue operations to a multi-cycle FPU.
//  Accepts a decoded FP op and its operands, pulses the FPU start, and stalls the PC until the FPU finishes.
//  Then produces a one-cycle register writeback and FPU-flag update.
//  Sits between the controller (FPUControl), the datapath (operands, result mux) and the FPU core.
// PARAMETERS
//  WIDTH    32  operand/result width
//  FLAG_W   4   FPU flag width (N,Z,C,V order as ALUFlags)
//  MAX_LAT  16  timeout limit in WAIT cycles (used only with FPU_SEQ_TIMEOUT_EN)
// PORTS
//  clk          in   1       clock, rising edge
//  reset        in   1       asynchronous, active-high
//  op_valid     in   1       current instruction is an FPU op (decoded, condition passed)
//  op_ctrl      in   2       FPUControl for the op
//  op_a, op_b   in   WIDTH   source operands from register file
//  op_rd        in   4       destination register
//  fpu_start    out  1       one-cycle start pulse to FPU
//  fpu_ctrl     out  2       registered op_ctrl, held stable from ISSUE through WAIT
//  fpu_a, fpu_b out  WIDTH   registered operands, held stable from ISSUE through WAIT
//  fpu_done     in   1       FPU result valid (single-cycle pulse)
//  fpu_result   in   WIDTH   FPU result, valid with fpu_done
//  fpu_flags    in   FLAG_W  FPU flags, valid with fpu_done
//  stall        out  1       hold PC and suppress core RegWrite/MemWrite
//  wb_en        out  1       write wb_data to wb_rd this cycle
//  wb_rd        out  4       writeback register
//  wb_data      out  WIDTH   captured result
//  flags_we     out  1       update FPUFlags register this cycle (same cycle as wb_en)
//  flags_out    out  FLAG_W  captured flags
//  busy         out  1       state != IDLE
//  timeout_err  out  1       sticky timeout indicator (tied 0 without macro)
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE. All outputs are 0, including fpu_start, stall, wb_en, flags_we and the data regs.
//    The FPU shares the same reset, so a mid-op reset abandons the op with no writeback.
//  - FSM states: IDLE, ISSUE, WAIT, WB.
//  - IDLE:
//    - op_valid=1: capture op_ctrl/op_a/op_b/op_rd, go to ISSUE.
//    - stall = op_valid, combinational in IDLE only, so the PC holds in the accept cycle.
//  - ISSUE:
//    - fpu_start=1 for exactly this cycle; stall=1.
//    - fpu_done=1 here goes to WB; otherwise go to WAIT.
//  - WAIT: stall=1. Go to WB on fpu_done. Capture fpu_result/fpu_flags on the transition edge.
//  - WB:
//    - wb_en=1, flags_we=1, stall=0, so the PC advances at the end of WB.
//    - Go to IDLE next cycle.
//    - op_valid in WB is the same instruction and is ignored.
//  - op_valid is sampled only in IDLE.
//  - fpu_done is sampled only in ISSUE/WAIT; a stray done in IDLE/WB is ignored.
//  - Latency: op accept to wb_en = 2 + N cycles, where N = number of WAIT cycles. Minimum 2 (done in ISSUE).
//  - Back-to-back ops: WB then IDLE, so the next op is accepted one cycle after WB. No overlap and no queueing.
// CONFIGURATION
//  - Macro FPU_SEQ_TIMEOUT_EN defined:
//    - WAIT counts cycles from 1 up to MAX_LAT.
//    - If the count reaches MAX_LAT without fpu_done, go to WB with wb_data=0, flags_out=0, and wb_en=0.
//    - flags_we=1 in that WB cycle.
//    - Set timeout_err, which stays 1 until reset.
//    - fpu_done on the MAX_LAT cycle wins over the timeout.
//  - Macro undefined: WAIT is unbounded, no counter logic is built, and timeout_err=0.
// STRUCTURE
//  - Package fpu_seq_pkg:
//    - state enum {IDLE,ISSUE,WAIT,WB}
//    - FPU op codes: ADD=2'b00, MUL=2'b01, SUB=2'b10, CMP=2'b11
//    - flag bit indices N=3, Z=2, C=1, V=0
//  - Sub-module fpu_seq_timer: the timeout counter with clear, enable and expired outputs. Instantiated only under FPU_SEQ_TIMEOUT_EN.
// TESTING
//  - Basic op:
//    - stimulus: op_valid, ctrl=01, a=0x40000000, b=0x40400000, rd=5; fpu_done 3 cycles after fpu_start with result=0x40C00000, flags=0.
//    - response: one fpu_start pulse; stall high for 5 cycles; wb_en=1 with rd=5 and data=0x40C00000 in the next cycle.
//  - Fast done: fpu_done in the ISSUE cycle -> wb_en exactly 2 cycles after accept; stall high for 2 cycles.
//  - Back-to-back:
//    - stimulus: two ops, each with done after 1 wait cycle.
//    - response: two separate wb_en pulses, one idle cycle between WB and the second accept, and exactly 2 fpu_start pulses.
//  - Mid-op reset:
//    - stimulus: assert reset in WAIT, then drive fpu_done next cycle.
//    - response: all outputs 0 immediately (async), no wb_en, state stays IDLE.
//  - Stray done: fpu_done pulse while IDLE -> no wb_en, no state change.
//  - With FPU_SEQ_TIMEOUT_EN and MAX_LAT=4: no fpu_done -> WB after 4 WAIT cycles with wb_en=0 and flags_we=1; timeout_err stays 1 until reset.

Source files
------------

// File: rtl/fpu_seq_pkg.sv
// fpu_seq_pkg: shared state encoding, FPU op codes and flag bit positions for the FPU sequencer.
package fpu_seq_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WB} state_e;
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_MUL = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b10;
    localparam logic [1:0] OP_CMP = 2'b11;
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;
endpackage

// File: rtl/fpu_seq_if.sv
// fpu_seq_if: op request, FPU handshake and writeback signals between core, sequencer and FPU.
interface fpu_seq_if #(
    parameter int WIDTH  = 32,
    parameter int FLAG_W = 4
);
    logic              op_valid;
    logic [1:0]        op_ctrl;
    logic [WIDTH-1:0]  op_a;
    logic [WIDTH-1:0]  op_b;
    logic [3:0]        op_rd;
    logic              fpu_start;
    logic [1:0]        fpu_ctrl;
    logic [WIDTH-1:0]  fpu_a;
    logic [WIDTH-1:0]  fpu_b;
    logic              fpu_done;
    logic [WIDTH-1:0]  fpu_result;
    logic [FLAG_W-1:0] fpu_flags;
    logic              stall;
    logic              wb_en;
    logic [3:0]        wb_rd;
    logic [WIDTH-1:0]  wb_data;
    logic              flags_we;
    logic [FLAG_W-1:0] flags_out;
    logic              busy;
    logic              timeout_err;
    modport slave (
        input  op_valid, op_ctrl, op_a, op_b, op_rd, fpu_done, fpu_result, fpu_flags,
        output fpu_start, fpu_ctrl, fpu_a, fpu_b, stall, wb_en, wb_rd, wb_data,
               flags_we, flags_out, busy, timeout_err
    );
    modport master (
        output op_valid, op_ctrl, op_a, op_b, op_rd, fpu_done, fpu_result, fpu_flags,
        input  fpu_start, fpu_ctrl, fpu_a, fpu_b, stall, wb_en, wb_rd, wb_data,
               flags_we, flags_out, busy, timeout_err
    );
endinterface

// File: rtl/fpu_seq_timer.sv
// fpu_seq_timer: counts WAIT cycles and flags the MAX_LAT-th one; cleared outside WAIT.
module fpu_seq_timer #(
    parameter int MAX_LAT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int CW = $clog2(MAX_LAT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    always_comb begin
        cnt_d   = clr ? '0 : en ? cnt_q + CW'(1) : cnt_q;
        expired = en && (cnt_q == CW'(MAX_LAT - 1));
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
endmodule

// File: rtl/fpu_seq_ctrl.sv
// fpu_seq_ctrl: issues one op to a multi-cycle FPU, stalls the core until done, then writes back.
// Optional WAIT timeout enabled by defining FPU_SEQ_TIMEOUT_EN.
module fpu_seq_ctrl
    import fpu_seq_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int FLAG_W  = 4,
    parameter int MAX_LAT = 16
) (
    input logic       clk,
    input logic       reset,
    fpu_seq_if.slave  bus
);
    state_e            state_q, state_d;
    logic [1:0]        ctrl_q, ctrl_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, data_q, data_d;
    logic [3:0]        rd_q, rd_d;
    logic [FLAG_W-1:0] flags_q, flags_d;
    logic              to_q, to_d, err_q, err_d;
    logic              expired;
`ifdef FPU_SEQ_TIMEOUT_EN
    fpu_seq_timer #(.MAX_LAT(MAX_LAT)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clr     (state_q != WAIT),
        .en      (state_q == WAIT),
        .expired (expired)
    );
`else
    assign expired = 1'b0;
`endif
    always_comb begin
        state_d = state_q;
        ctrl_d  = ctrl_q;
        a_d     = a_q;
        b_d     = b_q;
        rd_d    = rd_q;
        data_d  = data_q;
        flags_d = flags_q;
        to_d    = to_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (bus.op_valid) begin
                ctrl_d  = bus.op_ctrl;
                a_d     = bus.op_a;
                b_d     = bus.op_b;
                rd_d    = bus.op_rd;
                state_d = ISSUE;
            end
            ISSUE, WAIT: if (bus.fpu_done) begin
                data_d  = bus.fpu_result;
                flags_d = bus.fpu_flags;
                to_d    = 1'b0;
                state_d = WB;
            end else if (expired) begin
                // a timed-out op still closes with a flag update but never writes the register file
                data_d  = '0;
                flags_d = '0;
                to_d    = 1'b1;
                err_d   = 1'b1;
                state_d = WB;
            end else begin
                state_d = WAIT;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ctrl_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            rd_q    <= '0;
            data_q  <= '0;
            flags_q <= '0;
            to_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rd_q    <= rd_d;
            data_q  <= data_d;
            flags_q <= flags_d;
            to_q    <= to_d;
            err_q   <= err_d;
        end
    end
    assign bus.fpu_start   = state_q == ISSUE;
    assign bus.fpu_ctrl    = ctrl_q;
    assign bus.fpu_a       = a_q;
    assign bus.fpu_b       = b_q;
    assign bus.stall       = (state_q == IDLE) ? bus.op_valid : (state_q != WB);
    assign bus.wb_en       = (state_q == WB) && !to_q;
    assign bus.wb_rd       = rd_q;
    assign bus.wb_data     = data_q;
    assign bus.flags_we    = state_q == WB;
    assign bus.flags_out   = flags_q;
    assign bus.busy        = state_q != IDLE;
    assign bus.timeout_err = err_q;
endmodule

// File: tb/tb_fpu_seq_ctrl.sv
// tb_fpu_seq_ctrl: directed and random ops checked against a cycle-offset model of the op timeline.
module tb_fpu_seq_ctrl;
`ifdef FPU_SEQ_TIMEOUT_EN
    localparam int ML = 4;
`else
    localparam int ML = 16;
`endif
    logic clk = 1'b0;
    logic reset = 1'b1;
    int n_cmp = 0, n_bad = 0, n_start = 0, n_ops = 0;

    fpu_seq_if #(.WIDTH(32), .FLAG_W(4)) bus ();
    fpu_seq_ctrl #(.WIDTH(32), .FLAG_W(4), .MAX_LAT(ML)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (bus.fpu_start) n_start++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Timeline of one op, offsets from the accept cycle: 0 accept, 1 issue, 2..1+n wait, 2+n writeback.
    task automatic do_op(input logic [1:0] ctl, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] rd, input logic [31:0] res, input logic [3:0] fl,
                         input int n);
        bus.op_valid = 1'b1;
        bus.op_ctrl  = ctl;
        bus.op_a     = a;
        bus.op_b     = b;
        bus.op_rd    = rd;
        bus.fpu_done = 1'b0;
        @(negedge clk);
        chk1("accept_stall", bus.stall, 1'b1);
        chk1("accept_busy", bus.busy, 1'b0);
        chk1("accept_wb_en", bus.wb_en, 1'b0);
        tick();
        n_ops++;
        for (int c = 1; c <= 1 + n; c++) begin
            bus.op_valid   = 1'($urandom);
            bus.op_ctrl    = 2'($urandom);
            bus.op_a       = $urandom;
            bus.op_b       = $urandom;
            bus.op_rd      = 4'($urandom);
            bus.fpu_done   = (c == 1 + n);
            bus.fpu_result = (c == 1 + n) ? res : $urandom;
            bus.fpu_flags  = (c == 1 + n) ? fl : 4'($urandom);
            @(negedge clk);
            chk1("fpu_start", bus.fpu_start, c == 1);
            chk1("busy_stall", bus.stall, 1'b1);
            chk1("busy_wb_en", bus.wb_en, 1'b0);
            chk("fpu_a", bus.fpu_a, a);
            chk("fpu_b", bus.fpu_b, b);
            chk("fpu_ctrl", 32'(bus.fpu_ctrl), 32'(ctl));
            tick();
        end
        bus.op_valid   = 1'($urandom);
        bus.fpu_done   = 1'($urandom);
        bus.fpu_result = $urandom;
        bus.fpu_flags  = 4'($urandom);
        @(negedge clk);
        chk1("wb_en", bus.wb_en, 1'b1);
        chk1("wb_flags_we", bus.flags_we, 1'b1);
        chk1("wb_stall", bus.stall, 1'b0);
        chk("wb_rd", 32'(bus.wb_rd), 32'(rd));
        chk("wb_data", bus.wb_data, res);
        chk("flags_out", 32'(bus.flags_out), 32'(fl));
        chk1("timeout_err", bus.timeout_err, 1'b0);
        tick();
        bus.op_valid = 1'b0;
        bus.fpu_done = 1'b0;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) begin
            bus.op_valid   = 1'b0;
            bus.fpu_done   = 1'($urandom);
            bus.fpu_result = $urandom;
            @(negedge clk);
            chk1("idle_busy", bus.busy, 1'b0);
            chk1("idle_stall", bus.stall, 1'b0);
            chk1("idle_wb_en", bus.wb_en, 1'b0);
            chk1("idle_flags_we", bus.flags_we, 1'b0);
            tick();
        end
        bus.fpu_done = 1'b0;
    endtask

    initial begin
        bus.op_valid   = 1'b0;
        bus.op_ctrl    = '0;
        bus.op_a       = '0;
        bus.op_b       = '0;
        bus.op_rd      = '0;
        bus.fpu_done   = 1'b0;
        bus.fpu_result = '0;
        bus.fpu_flags  = '0;
        #2;
        chk1("rst_busy", bus.busy, 1'b0);
        chk1("rst_stall", bus.stall, 1'b0);
        chk1("rst_start", bus.fpu_start, 1'b0);
        chk1("rst_wb_en", bus.wb_en, 1'b0);
        chk1("rst_flags_we", bus.flags_we, 1'b0);
        chk("rst_wb_data", bus.wb_data, 32'h0);
        chk("rst_fpu_a", bus.fpu_a, 32'h0);
        chk1("rst_timeout", bus.timeout_err, 1'b0);
        tick();
        reset = 1'b0;
        idle(2);
        do_op(2'b01, 32'h4000_0000, 32'h4040_0000, 4'd5, 32'h40C0_0000, 4'h0, 3);
        idle(1);
        do_op(2'b00, 32'h3F80_0000, 32'hBF80_0000, 4'd9, 32'h0, 4'b0100, 0);
        idle(1);
        do_op(2'b10, 32'h1, 32'h2, 4'd1, 32'hFFFF_FFFF, 4'b1000, 1);
        do_op(2'b11, 32'h3, 32'h4, 4'd2, 32'h1234_5678, 4'b0011, 1);
        idle(3);
        for (int i = 0; i < 24; i++) begin
            do_op(2'($urandom), $urandom, $urandom, 4'($urandom), $urandom, 4'($urandom),
                  int'($urandom_range(0, 4)));
            if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 2)));
        end
        bus.op_valid = 1'b1;
        bus.op_a     = 32'hDEAD_BEEF;
        tick();
        bus.op_valid = 1'b0;
        tick();
        tick();
        n_ops++;
        chk1("mid_busy", bus.busy, 1'b1);
        reset = 1'b1;
        #1;
        chk1("mid_rst_busy", bus.busy, 1'b0);
        chk1("mid_rst_stall", bus.stall, 1'b0);
        chk1("mid_rst_start", bus.fpu_start, 1'b0);
        chk("mid_rst_fpu_a", bus.fpu_a, 32'h0);
        chk("mid_rst_wb_rd", 32'(bus.wb_rd), 32'h0);
        tick();
        reset = 1'b0;
        bus.fpu_done   = 1'b1;
        bus.fpu_result = 32'h5555_5555;
        @(negedge clk);
        chk1("post_rst_wb_en", bus.wb_en, 1'b0);
        chk1("post_rst_busy", bus.busy, 1'b0);
        tick();
        idle(2);
        chk("wb_data_after_abort", bus.wb_data, 32'h0);
`ifdef FPU_SEQ_TIMEOUT_EN
        bus.op_valid = 1'b1;
        bus.op_rd    = 4'd7;
        tick();
        bus.op_valid = 1'b0;
        n_ops++;
        for (int c = 1; c <= 1 + ML; c++) begin
            @(negedge clk);
            chk1("to_stall", bus.stall, 1'b1);
            chk1("to_start", bus.fpu_start, c == 1);
            tick();
        end
        @(negedge clk);
        chk1("to_wb_en", bus.wb_en, 1'b0);
        chk1("to_flags_we", bus.flags_we, 1'b1);
        chk("to_wb_data", bus.wb_data, 32'h0);
        chk("to_flags_out", 32'(bus.flags_out), 32'h0);
        chk1("to_err", bus.timeout_err, 1'b1);
        tick();
        idle(3);
        chk1("to_err_sticky", bus.timeout_err, 1'b1);
        reset = 1'b1;
        #1;
        chk1("to_err_cleared", bus.timeout_err, 1'b0);
        tick();
        reset = 1'b0;
`endif
        chk("start_count", n_start, n_ops);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
